// File: rtl/pic_fetch_pc_pkg.sv
// Shared definitions for the PIC16F-style fetch path: op encodings and core sizes.
package pic_defines;

  localparam int PIC_ADDR_WIDTH  = 13;
  localparam int PIC_STACK_DEPTH = 8;
  localparam int PIC_LIT_WIDTH   = 11;

  // Codes 6 and 7 are left unnamed; the fetch unit treats them as OP_INC.
  typedef enum logic [2:0] {
    OP_INC    = 3'd0,
    OP_GOTO   = 3'd1,
    OP_CALL   = 3'd2,
    OP_RETURN = 3'd3,
    OP_SKIP   = 3'd4,
    OP_PCL_WR = 3'd5
  } op_e;

  function automatic logic is_transfer(input logic [2:0] op);
    return op inside {OP_GOTO, OP_CALL, OP_RETURN, OP_SKIP, OP_PCL_WR};
  endfunction

endpackage

// File: rtl/pic_fetch_pc_if.sv
// Control/fetch bundle between the decode stage (master) and pic_fetch_pc (slave).
interface pic_fetch_pc_if #(
  parameter int ADDR_WIDTH = 13,
  parameter int LIT_WIDTH  = 11
);

  logic                  pc_en;
  logic [2:0]            op;
  logic [LIT_WIDTH-1:0]  lit;
  logic [4:0]            pclath;
  logic [7:0]            pcl_wdata;
  logic [ADDR_WIDTH-1:0] pc;
  logic                  pmem_rd_en;
  logic                  pmem_flush;
  logic                  stack_ovf;
  logic                  stack_unf;

  modport master (
    output pc_en, op, lit, pclath, pcl_wdata,
    input  pc, pmem_rd_en, pmem_flush, stack_ovf, stack_unf
  );

  modport slave (
    input  pc_en, op, lit, pclath, pcl_wdata,
    output pc, pmem_rd_en, pmem_flush, stack_ovf, stack_unf
  );

endinterface

// File: rtl/pic_fetch_pc_stack.sv
// Circular PIC return stack; the depth counter and sticky ovf/unf flags exist
// only when PIC_STACK_FLAGS_EN is defined, otherwise the flags are tied low.
module pic_return_stack #(
  parameter int ADDR_WIDTH  = 13,
  parameter int STACK_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic [ADDR_WIDTH-1:0] push_data,
  output logic [ADDR_WIDTH-1:0] pop_data,
  output logic                  ovf,
  output logic                  unf
);

  localparam int PTR_W = $clog2(STACK_DEPTH);

  logic [ADDR_WIDTH-1:0] stack [STACK_DEPTH];
  logic [PTR_W-1:0]      sp;

  // The pointer wraps freely, so a ninth push silently overwrites the oldest entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      sp <= '0;
      for (int i = 0; i < STACK_DEPTH; i++) stack[i] <= '0;
    end else if (push) begin
      stack[sp] <= push_data;
      sp        <= sp + PTR_W'(1);
    end else if (pop) begin
      sp <= sp - PTR_W'(1);
    end
  end

  assign pop_data = stack[sp - PTR_W'(1)];

`ifdef PIC_STACK_FLAGS_EN
  logic [PTR_W:0] depth;
  logic           ovf_q;
  logic           unf_q;

  // Depth saturates at both ends; the stack itself keeps wrapping regardless.
  always_ff @(posedge clk) begin
    if (rst) begin
      depth <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else if (push) begin
      if (depth == (PTR_W+1)'(STACK_DEPTH)) ovf_q <= 1'b1;
      else                                  depth <= depth + 1'b1;
    end else if (pop) begin
      if (depth == '0) unf_q <= 1'b1;
      else             depth <= depth - 1'b1;
    end
  end

  assign ovf = ovf_q;
  assign unf = unf_q;
`else
  assign ovf = 1'b0;
  assign unf = 1'b0;
`endif

endmodule

// File: rtl/pic_fetch_pc.sv
// PIC16F-style program counter and fetch controller with two-cycle control transfers.
// Optional sticky stack flags are enabled by defining PIC_STACK_FLAGS_EN.
module pic_fetch_pc
  import pic_defines::*;
#(
  parameter int ADDR_WIDTH  = PIC_ADDR_WIDTH,
  parameter int STACK_DEPTH = PIC_STACK_DEPTH,
  parameter int LIT_WIDTH   = PIC_LIT_WIDTH
) (
  input logic          clk,
  input logic          rst,
  pic_fetch_pc_if.slave bus
);

  logic [ADDR_WIDTH-1:0] pc_q;
  logic [ADDR_WIDTH-1:0] next_pc;
  logic [ADDR_WIDTH-1:0] pop_data;
  logic                  push_req;
  logic                  pop_req;

  // pc_q already holds the return address when CALL executes, so it is pushed as-is.
  always_comb begin
    next_pc  = pc_q + ADDR_WIDTH'(1);
    push_req = 1'b0;
    pop_req  = 1'b0;
    case (bus.op)
      OP_GOTO:   next_pc = ADDR_WIDTH'({bus.pclath[4:3], bus.lit[LIT_WIDTH-1:0]});
      OP_CALL: begin
        next_pc  = ADDR_WIDTH'({bus.pclath[4:3], bus.lit[LIT_WIDTH-1:0]});
        push_req = 1'b1;
      end
      OP_RETURN: begin
        next_pc = pop_data;
        pop_req = 1'b1;
      end
      OP_PCL_WR: next_pc = ADDR_WIDTH'({bus.pclath, bus.pcl_wdata});
      default:   next_pc = pc_q + ADDR_WIDTH'(1);
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)            pc_q <= '0;
    else if (bus.pc_en) pc_q <= next_pc;
  end

  pic_return_stack #(
    .ADDR_WIDTH  (ADDR_WIDTH),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk       (clk),
    .rst       (rst),
    .push      (push_req & bus.pc_en),
    .pop       (pop_req & bus.pc_en),
    .push_data (pc_q),
    .pop_data  (pop_data),
    .ovf       (bus.stack_ovf),
    .unf       (bus.stack_unf)
  );

  // The flush turns the already-fetched wrong-path word into a NOP on the same edge.
  assign bus.pc         = pc_q;
  assign bus.pmem_rd_en = bus.pc_en;
  assign bus.pmem_flush = !rst && bus.pc_en && is_transfer(bus.op);

endmodule

// File: tb/tb_pic_fetch_pc.sv
// Self-checking bench for pic_fetch_pc: table-driven vectors plus call/return and reset sequences.
module tb_pic_fetch_pc;
  import pic_defines::*;

`ifdef PIC_STACK_FLAGS_EN
  localparam logic FLAG_EXP = 1'b1;
`else
  localparam logic FLAG_EXP = 1'b0;
`endif

  typedef struct {
    logic [2:0]  op;
    logic [10:0] lit;
    logic [4:0]  pclath;
    logic [7:0]  wdata;
    logic        en;
    logic [12:0] exp_pc;
    logic        exp_flush;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  logic [12:0] sb_q [$];
  vec_t        vecs [19];

  logic [12:0] model_stack [8];
  logic [2:0]  model_sp;
  logic [12:0] cur_pc;

  pic_fetch_pc_if #(.ADDR_WIDTH(13), .LIT_WIDTH(11)) bus ();

  pic_fetch_pc dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Compares the registered pc against the oldest scoreboard entry.
  task automatic check_output(input string tag);
    logic [12:0] exp;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s scoreboard empty: actual=0 required=1 entries", tag);
    end else begin
      exp = sb_q.pop_front();
      check({tag, " pc"}, 32'(bus.pc), 32'(exp));
    end
  endtask

  // Drives one instruction cycle at the negedge, checks combinational outputs,
  // then checks pc just after the posedge.
  task automatic apply_stimulus(input logic [2:0] op, input logic [10:0] lit,
                                input logic [4:0] pclath, input logic [7:0] wdata,
                                input logic en, input logic rst_i,
                                input logic [12:0] exp_pc, input logic exp_flush,
                                input string tag);
    rst           = rst_i;
    bus.pc_en     = en;
    bus.op        = op;
    bus.lit       = lit;
    bus.pclath    = pclath;
    bus.pcl_wdata = wdata;
    #1;
    check({tag, " flush"}, 32'(bus.pmem_flush), 32'(exp_flush));
    check({tag, " rd_en"}, 32'(bus.pmem_rd_en), 32'(en));
    sb_q.push_back(exp_pc);
    @(posedge clk);
    #1;
    check_output(tag);
    cur_pc = exp_pc;
    @(negedge clk);
  endtask

  task automatic do_call(input logic [10:0] lit, input string tag);
    model_stack[model_sp] = cur_pc;
    model_sp              = model_sp + 3'd1;
    apply_stimulus(OP_CALL, lit, 5'h00, 8'h00, 1'b1, 1'b0, {2'b00, lit}, 1'b1, tag);
  endtask

  task automatic do_return(input string tag);
    logic [12:0] exp;
    model_sp = model_sp - 3'd1;
    exp      = model_stack[model_sp];
    apply_stimulus(OP_RETURN, 11'h000, 5'h00, 8'h00, 1'b1, 1'b0, exp, 1'b1, tag);
  endtask

  initial begin
    vecs[0]  = '{OP_INC,    11'h000, 5'h00, 8'h00, 1'b1, 13'h0001, 1'b0};
    vecs[1]  = '{OP_INC,    11'h000, 5'h00, 8'h00, 1'b1, 13'h0002, 1'b0};
    vecs[2]  = '{OP_INC,    11'h000, 5'h00, 8'h00, 1'b1, 13'h0003, 1'b0};
    vecs[3]  = '{OP_INC,    11'h000, 5'h00, 8'h00, 1'b1, 13'h0004, 1'b0};
    vecs[4]  = '{OP_PCL_WR, 11'h000, 5'h00, 8'h05, 1'b1, 13'h0005, 1'b1};
    vecs[5]  = '{OP_GOTO,   11'h001, 5'h18, 8'h00, 1'b1, 13'h1801, 1'b1};
    vecs[6]  = '{OP_PCL_WR, 11'h000, 5'h00, 8'h10, 1'b1, 13'h0010, 1'b1};
    vecs[7]  = '{OP_CALL,   11'h100, 5'h00, 8'h00, 1'b1, 13'h0100, 1'b1};
    vecs[8]  = '{OP_RETURN, 11'h000, 5'h00, 8'h00, 1'b1, 13'h0010, 1'b1};
    vecs[9]  = '{OP_GOTO,   11'h555, 5'h18, 8'h00, 1'b0, 13'h0010, 1'b0};
    vecs[10] = '{OP_GOTO,   11'h555, 5'h18, 8'h00, 1'b0, 13'h0010, 1'b0};
    vecs[11] = '{OP_GOTO,   11'h555, 5'h18, 8'h00, 1'b0, 13'h0010, 1'b0};
    vecs[12] = '{OP_PCL_WR, 11'h000, 5'h1F, 8'hFF, 1'b1, 13'h1FFF, 1'b1};
    vecs[13] = '{OP_INC,    11'h000, 5'h00, 8'h00, 1'b1, 13'h0000, 1'b0};
    vecs[14] = '{OP_PCL_WR, 11'h000, 5'h03, 8'h7F, 1'b1, 13'h037F, 1'b1};
    vecs[15] = '{3'd6,      11'h7FF, 5'h1F, 8'hFF, 1'b1, 13'h0380, 1'b0};
    vecs[16] = '{3'd7,      11'h7FF, 5'h1F, 8'hFF, 1'b1, 13'h0381, 1'b0};
    vecs[17] = '{OP_SKIP,   11'h000, 5'h00, 8'h00, 1'b1, 13'h0382, 1'b1};
    vecs[18] = '{OP_GOTO,   11'h7FF, 5'h08, 8'h00, 1'b1, 13'h0FFF, 1'b1};

    model_sp = 3'd0;
    for (int i = 0; i < 8; i++) model_stack[i] = 13'h0000;
    cur_pc = 13'h0000;

    // Reset with a GOTO presented: reset wins and no flush is raised.
    apply_stimulus(OP_GOTO, 11'h123, 5'h18, 8'h00, 1'b1, 1'b1, 13'h0000, 1'b0, "reset0");
    apply_stimulus(OP_GOTO, 11'h123, 5'h18, 8'h00, 1'b1, 1'b1, 13'h0000, 1'b0, "reset1");
    check("reset ovf", 32'(bus.stack_ovf), 32'h0);
    check("reset unf", 32'(bus.stack_unf), 32'h0);

    for (int i = 0; i < 19; i++) begin
      apply_stimulus(vecs[i].op, vecs[i].lit, vecs[i].pclath, vecs[i].wdata, vecs[i].en,
                     1'b0, vecs[i].exp_pc, vecs[i].exp_flush, $sformatf("vec%0d", i));
    end
    check("table ovf", 32'(bus.stack_ovf), 32'h0);
    check("table unf", 32'(bus.stack_unf), 32'h0);

    // Nine nested calls then nine returns: the ninth return wraps to the ninth call's address.
    apply_stimulus(OP_PCL_WR, 11'h000, 5'h02, 8'h00, 1'b1, 1'b0, 13'h0200, 1'b1, "seed200");
    for (int i = 0; i < 9; i++) begin
      do_call(11'h300 + 11'(i * 16), $sformatf("call%0d", i));
      if (i == 7) check("ovf after 8 calls", 32'(bus.stack_ovf), 32'h0);
    end
    check("ovf after 9 calls", 32'(bus.stack_ovf), 32'(FLAG_EXP));
    for (int i = 0; i < 9; i++) begin
      do_return($sformatf("ret%0d", i));
      if (i == 7) check("unf after 8 returns", 32'(bus.stack_unf), 32'h0);
      if (i == 8) check("ret9 wraps to call9 addr", 32'(bus.pc), 32'h0370);
    end
    check("unf after 9 returns", 32'(bus.stack_unf), 32'(FLAG_EXP));

    // Reset after two calls clears pc, flags and stack contents.
    apply_stimulus(OP_PCL_WR, 11'h000, 5'h00, 8'h40, 1'b1, 1'b0, 13'h0040, 1'b1, "seed040");
    do_call(11'h050, "rcall0");
    do_call(11'h060, "rcall1");
    apply_stimulus(OP_GOTO, 11'h222, 5'h18, 8'h00, 1'b1, 1'b1, 13'h0000, 1'b0, "midrst");
    check("midrst ovf", 32'(bus.stack_ovf), 32'h0);
    check("midrst unf", 32'(bus.stack_unf), 32'h0);
    apply_stimulus(OP_RETURN, 11'h000, 5'h00, 8'h00, 1'b1, 1'b0, 13'h0000, 1'b1, "postrst ret");
    check("postrst unf", 32'(bus.stack_unf), 32'(FLAG_EXP));
    check("postrst ovf", 32'(bus.stack_ovf), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
